toggle_cov_monitor: RTL and testbench

- Parametrised hardware toggle-coverage monitor.
- Samples a WIDTH-bit watched bus every enabled clock and keeps saturating rise (0→1) and fall (1→0) counters for each bit.
- Bits can be excluded at elaboration time, which is the hardware equivalent of coverage-off regions.
- Exposes a one-cycle-latency readout port, a sticky saturation flag and a registered "fully covered" flag. It sits beside the design under test in regression benches so that toggle counts can be cross-checked against the tool's coverage output.

---
 rtl/toggle_cov_monitor_if.sv | 38 +++
 rtl/toggle_cov_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_toggle_cov_monitor.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_cov_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : toggle_cov_monitor_if
// Description : Bus bundle for the toggle-coverage monitor. Carries the
//               sampling controls, the watched bus, the read request/response
//               port and the status flags.
// Modports    : master - drives en, clr, sig, rd_req, rd_idx; observes results
//               slave  - the monitor itself
// Revision    : 1.0 - initial release
// ============================================================================
interface toggle_cov_monitor_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int IDX_W = $clog2(WIDTH + 1)
) ();
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] sig;
  logic             rd_req;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic             rd_err;
  logic [CNT_W-1:0] rd_rise;
  logic [CNT_W-1:0] rd_fall;
  logic             covered;
  logic             sat;

  modport master (
    output en, clr, sig, rd_req, rd_idx,
    input  rd_valid, rd_err, rd_rise, rd_fall, covered, sat
  );

  modport slave (
    input  en, clr, sig, rd_req, rd_idx,
    output rd_valid, rd_err, rd_rise, rd_fall, covered, sat
  );
endinterface
`default_nettype wire

// File: rtl/toggle_cov_monitor.sv
`default_nettype none
// ============================================================================
// Module      : toggle_cov_monitor
// Description : Per-bit toggle-coverage monitor. Keeps saturating rise and
//               fall counters for each included bit of a watched bus, with a
//               one-cycle-latency readout, a sticky saturation flag and a
//               registered fully-covered flag.
// Ports       : clk      - clock, all logic on posedge
//               rst      - synchronous active-high reset
//               bus      - toggle_cov_monitor_if.slave
//                 en       sampling enable
//                 clr      synchronous clear of counters and flags
//                 sig      watched bus (WIDTH bits)
//                 rd_req   read request, rd_idx selects the bit
//                 rd_valid read data valid one cycle after rd_req
//                 rd_err   rd_idx out of range (qualified by rd_valid)
//                 rd_rise  rise count of the requested bit
//                 rd_fall  fall count of the requested bit
//                 covered  every included bit has risen and fallen
//                 sat      sticky, some counter reached its maximum
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_cov_monitor #(
  parameter int               WIDTH = 8,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] MASK  = {WIDTH{1'b1}},
  parameter int               IDX_W = $clog2(WIDTH + 1)
) (
  input logic                 clk,
  input logic                 rst,
  toggle_cov_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] c_IDX_LIMIT = IDX_W'(WIDTH);

  // The first enabled sample after reset or a disabled gap only loads the
  // reference value; counting starts from the following sample.
  typedef enum logic [0:0] {
    ST_UNPRIMED = 1'b0,
    ST_PRIMED   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_count;
  logic [WIDTH-1:0] r_prev;

  logic [CNT_W-1:0] w_rise_cur [WIDTH];
  logic [CNT_W-1:0] w_fall_cur [WIDTH];
  logic [CNT_W-1:0] w_rise_nxt [WIDTH];
  logic [CNT_W-1:0] w_fall_nxt [WIDTH];

  logic             w_cov_nxt;
  logic             w_any_max;
  logic [CNT_W-1:0] w_rd_rise;
  logic [CNT_W-1:0] w_rd_fall;
  logic             w_rd_err;

  logic             r_covered;
  logic             r_sat;
  logic             r_rd_valid;
  logic             r_rd_err;
  logic [CNT_W-1:0] r_rd_rise;
  logic [CNT_W-1:0] r_rd_fall;

  // --------------------------------------------------------------------------
  // Priming FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_UNPRIMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count     = 1'b0;
    case (r_state)
      ST_UNPRIMED: begin
        if (bus.en) w_state_nxt = ST_PRIMED;
      end
      ST_PRIMED: begin
        if (bus.en) w_count = 1'b1;
        else        w_state_nxt = ST_UNPRIMED;
      end
      default: w_state_nxt = ST_UNPRIMED;
    endcase
  end

  // Reference sample follows sig only while enabled, so changes during a
  // disabled gap are never seen as edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
    end else if (bus.en) begin
      r_prev <= bus.sig;
    end
  end

  // --------------------------------------------------------------------------
  // Per-bit counters; excluded bits have no storage and read as zero.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (MASK[gi]) begin : g_cnt
      logic [CNT_W-1:0] r_rise;
      logic [CNT_W-1:0] r_fall;
      logic             w_rise_edge;
      logic             w_fall_edge;

      assign w_rise_edge = w_count & ~r_prev[gi] &  bus.sig[gi];
      assign w_fall_edge = w_count &  r_prev[gi] & ~bus.sig[gi];

      // clr wins over a same-cycle edge.
      assign w_rise_nxt[gi] = bus.clr ? '0 :
                              (w_rise_edge && (r_rise != c_CNT_MAX)) ? r_rise + 1'b1 :
                              r_rise;
      assign w_fall_nxt[gi] = bus.clr ? '0 :
                              (w_fall_edge && (r_fall != c_CNT_MAX)) ? r_fall + 1'b1 :
                              r_fall;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rise <= '0;
          r_fall <= '0;
        end else begin
          r_rise <= w_rise_nxt[gi];
          r_fall <= w_fall_nxt[gi];
        end
      end

      assign w_rise_cur[gi] = r_rise;
      assign w_fall_cur[gi] = r_fall;
    end else begin : g_nocnt
      assign w_rise_cur[gi] = '0;
      assign w_fall_cur[gi] = '0;
      assign w_rise_nxt[gi] = '0;
      assign w_fall_nxt[gi] = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Status flags
  // --------------------------------------------------------------------------
  // covered looks at post-update counter values so it rises on the cycle
  // after the completing edge; excluded bits never hold it low.
  always_comb begin
    w_cov_nxt = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (MASK[i] && ((w_rise_nxt[i] == '0) || (w_fall_nxt[i] == '0))) begin
        w_cov_nxt = 1'b0;
      end
    end
  end

  // sat looks at the registered counters, so it follows one cycle after a
  // counter shows its maximum.
  always_comb begin
    w_any_max = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((w_rise_cur[i] == c_CNT_MAX) || (w_fall_cur[i] == c_CNT_MAX)) begin
        w_any_max = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_covered <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_covered <= bus.clr ? 1'b0 : w_cov_nxt;
      r_sat     <= bus.clr ? 1'b0 : (r_sat | w_any_max);
    end
  end

  // --------------------------------------------------------------------------
  // Read port: returns counter values as they stood before this cycle's
  // update. Out-of-range indices match no bit and so read zero.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_rise = '0;
    w_rd_fall = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.rd_idx == IDX_W'(i)) begin
        w_rd_rise = w_rise_cur[i];
        w_rd_fall = w_fall_cur[i];
      end
    end
  end

  assign w_rd_err = (bus.rd_idx >= c_IDX_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_rise  <= '0;
      r_rd_fall  <= '0;
    end else begin
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        r_rd_err  <= w_rd_err;
        r_rd_rise <= w_rd_rise;
        r_rd_fall <= w_rd_fall;
      end
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_err   = r_rd_err;
  assign bus.rd_rise  = r_rd_rise;
  assign bus.rd_fall  = r_rd_fall;
  assign bus.covered  = r_covered;
  assign bus.sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_toggle_cov_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_cov_monitor
// Description : Self-checking bench for toggle_cov_monitor. Three instances:
//               A (WIDTH=8, CNT_W=8, full mask), B (CNT_W=2), C (MASK=8'hFE).
//               Table-driven count pattern, directed corner sequences and a
//               randomized run against a behavioural model of instance A.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_cov_monitor;

  logic clk;
  logic rst;

  toggle_cov_monitor_if #(.WIDTH(8), .CNT_W(8)) if_a ();
  toggle_cov_monitor_if #(.WIDTH(8), .CNT_W(2)) if_b ();
  toggle_cov_monitor_if #(.WIDTH(8), .CNT_W(8)) if_c ();

  toggle_cov_monitor #(.WIDTH(8), .CNT_W(8), .MASK(8'hFF)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  toggle_cov_monitor #(.WIDTH(8), .CNT_W(2), .MASK(8'hFF)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );
  toggle_cov_monitor #(.WIDTH(8), .CNT_W(8), .MASK(8'hFE)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_a.en = 0; if_a.clr = 0; if_a.rd_req = 0;
    if_b.en = 0; if_b.clr = 0; if_b.rd_req = 0;
    if_c.en = 0; if_c.clr = 0; if_c.rd_req = 0;
    step();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- model --
  localparam int M_MAX = 255;
  int         m_rise [8];
  int         m_fall [8];
  logic [7:0] m_prev;
  bit         m_primed, m_sat, m_cov, m_valid, m_err;
  int         m_rr, m_rf;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_rise[i] = 0; m_fall[i] = 0; end
    m_prev = 0; m_primed = 0; m_sat = 0; m_cov = 0;
    m_valid = 0; m_err = 0; m_rr = 0; m_rf = 0;
  endtask

  task automatic model_step(input logic en, input logic clr, input logic [7:0] s,
                            input logic req, input logic [3:0] idx);
    bit any_max;
    any_max = 0;
    for (int i = 0; i < 8; i++)
      if (m_rise[i] == M_MAX || m_fall[i] == M_MAX) any_max = 1;
    m_valid = req;
    if (req) begin
      if (idx >= 8) begin m_err = 1; m_rr = 0; m_rf = 0; end
      else begin m_err = 0; m_rr = m_rise[idx]; m_rf = m_fall[idx]; end
    end
    if (clr) begin
      for (int i = 0; i < 8; i++) begin m_rise[i] = 0; m_fall[i] = 0; end
    end else if (m_primed && en) begin
      for (int i = 0; i < 8; i++) begin
        if (!m_prev[i] && s[i] && m_rise[i] < M_MAX) m_rise[i]++;
        if (m_prev[i] && !s[i] && m_fall[i] < M_MAX) m_fall[i]++;
      end
    end
    m_sat = clr ? 0 : (m_sat || any_max);
    m_cov = !clr;
    for (int i = 0; i < 8; i++)
      if (m_rise[i] == 0 || m_fall[i] == 0) m_cov = 0;
    m_primed = en;
    if (en) m_prev = s;
  endtask

  // ---------------------------------------------------------------- table --
  typedef struct {
    logic [7:0] sig;
    logic       en;
    logic       req;
    logic [3:0] idx;
    logic       exp_valid;
    logic [7:0] exp_rise;
    logic [7:0] exp_fall;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rnd;
    logic        r_en, r_clr, r_req;
    logic [7:0]  r_sig;
    logic [3:0]  r_idx;

    for (int k = 0; k < 10; k++)
      tbl[k] = '{8'(k + 1), 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 8'd0};
    tbl[10] = '{8'd10, 1'b1, 1'b1, 4'd0, 1'b1, 8'd4, 8'd5};
    tbl[11] = '{8'd10, 1'b1, 1'b1, 4'd1, 1'b1, 8'd3, 8'd2};
    tbl[12] = '{8'd10, 1'b1, 1'b1, 4'd2, 1'b1, 8'd1, 8'd1};
    tbl[13] = '{8'd10, 1'b1, 1'b1, 4'd3, 1'b1, 8'd1, 8'd0};
    tbl[14] = '{8'd10, 1'b1, 1'b1, 4'd4, 1'b1, 8'd0, 8'd0};

    rst = 1'b1;
    if_a.en = 0; if_a.clr = 0; if_a.sig = 0; if_a.rd_req = 0; if_a.rd_idx = 0;
    if_b.en = 0; if_b.clr = 0; if_b.sig = 0; if_b.rd_req = 0; if_b.rd_idx = 0;
    if_c.en = 0; if_c.clr = 0; if_c.sig = 0; if_c.rd_req = 0; if_c.rd_idx = 0;

    // ---- reset state ----
    step();
    chk("reset rd_valid", if_a.rd_valid, 0);
    chk("reset rd_err",   if_a.rd_err,   0);
    chk("reset rd_rise",  if_a.rd_rise,  0);
    chk("reset rd_fall",  if_a.rd_fall,  0);
    chk("reset covered",  if_a.covered,  0);
    chk("reset sat",      if_a.sat,      0);
    rst = 1'b0;
    step();
    chk("idle covered", if_a.covered, 0);

    // ---- count pattern, table driven ----
    do_reset();
    for (int k = 0; k < 15; k++) begin
      if_a.sig = tbl[k].sig; if_a.en = tbl[k].en;
      if_a.rd_req = tbl[k].req; if_a.rd_idx = tbl[k].idx;
      step();
      chk($sformatf("tbl%0d rd_valid", k), if_a.rd_valid, tbl[k].exp_valid);
      chk($sformatf("tbl%0d covered", k), if_a.covered, 0);
      if (tbl[k].exp_valid) begin
        chk($sformatf("tbl%0d rd_rise", k), if_a.rd_rise, tbl[k].exp_rise);
        chk($sformatf("tbl%0d rd_fall", k), if_a.rd_fall, tbl[k].exp_fall);
      end
    end
    if_a.rd_req = 0;

    // ---- saturation on B (CNT_W=2) ----
    do_reset();
    chk("sat after reset", if_b.sat, 0);
    if_b.en = 1;
    for (int k = 0; k < 10; k++) begin
      if_b.sig = 8'(k & 1);
      step();
    end
    if_b.en = 0;
    step();
    if_b.rd_req = 1; if_b.rd_idx = 0;
    step();
    if_b.rd_req = 0;
    chk("sat rise",  if_b.rd_rise, 3);
    chk("sat fall",  if_b.rd_fall, 3);
    chk("sat flag",  if_b.sat,     1);
    if_b.clr = 1;
    step();
    if_b.clr = 0;
    chk("clr sat", if_b.sat, 0);
    if_b.rd_req = 1; if_b.rd_idx = 0;
    step();
    if_b.rd_req = 0;
    chk("clr rise", if_b.rd_rise, 0);
    chk("clr fall", if_b.rd_fall, 0);
    step();
    chk("clr sat stays", if_b.sat, 0);

    // ---- mask on C (MASK=FE) ----
    do_reset();
    if_c.en = 1; if_c.sig = 8'h00; step();
    if_c.sig = 8'h03; step();
    if_c.sig = 8'h00; step();
    chk("mask covered early", if_c.covered, 0);
    if_c.rd_req = 1; if_c.rd_idx = 0; step();
    chk("mask b0 rise", if_c.rd_rise, 0);
    chk("mask b0 fall", if_c.rd_fall, 0);
    if_c.rd_idx = 1; step();
    if_c.rd_req = 0;
    chk("mask b1 rise", if_c.rd_rise, 1);
    chk("mask b1 fall", if_c.rd_fall, 1);
    if_c.sig = 8'hFC; step();
    chk("mask cov after rises", if_c.covered, 0);
    if_c.sig = 8'h04; step();
    chk("mask cov one left", if_c.covered, 0);
    if_c.sig = 8'h00; step();
    chk("mask cov complete", if_c.covered, 1);

    // ---- enable gap on A ----
    do_reset();
    if_a.en = 1; if_a.sig = 0; step(); step();
    if_a.en = 0; if_a.sig = 1; step();
    if_a.en = 1; step();
    if_a.rd_req = 1; if_a.rd_idx = 0; step();
    if_a.rd_req = 0;
    chk("gap rise", if_a.rd_rise, 0);
    chk("gap fall", if_a.rd_fall, 0);
    if_a.sig = 0; step();
    if_a.rd_req = 1; step();
    chk("gap fall after", if_a.rd_fall, 1);

    // ---- read semantics on A (continues: rise0 fall1, prev=0) ----
    if_a.sig = 1; if_a.rd_idx = 0; step();
    chk("rd same-cycle old", if_a.rd_rise, 0);
    step();
    chk("rd next-cycle new", if_a.rd_rise, 1);
    if_a.rd_idx = 9; step();
    chk("rd9 valid", if_a.rd_valid, 1);
    chk("rd9 err",   if_a.rd_err,   1);
    chk("rd9 rise",  if_a.rd_rise,  0);
    chk("rd9 fall",  if_a.rd_fall,  0);
    if_a.rd_req = 0; step();
    chk("idle valid", if_a.rd_valid, 0);
    chk("idle err hold", if_a.rd_err, 1);

    // ---- reset mid-run on A ----
    do_reset();
    if_a.en = 1;
    for (int k = 0; k < 6; k++) begin
      if_a.sig = 8'(k & 1);
      if_a.rd_req = (k == 5); if_a.rd_idx = 0;
      step();
    end
    chk("pre-rst rise", if_a.rd_rise, 2);
    rst = 1; if_a.rd_req = 1; step();
    rst = 0; if_a.rd_req = 0;
    chk("mid-rst valid",   if_a.rd_valid, 0);
    chk("mid-rst rise",    if_a.rd_rise,  0);
    chk("mid-rst fall",    if_a.rd_fall,  0);
    chk("mid-rst err",     if_a.rd_err,   0);
    chk("mid-rst covered", if_a.covered,  0);
    chk("mid-rst sat",     if_a.sat,      0);
    if_a.sig = 1; step();
    if_a.rd_req = 1; step();
    if_a.rd_req = 0;
    chk("post-rst ref rise", if_a.rd_rise, 0);
    chk("post-rst ref fall", if_a.rd_fall, 0);

    // ---- randomized run on A against the model ----
    do_reset();
    model_reset();
    if_a.sig = 0;
    for (int c = 0; c < 400; c++) begin
      rnd   = $urandom;
      r_en  = (rnd[23:20] < 4'd13);
      r_clr = (rnd[29:24] == 6'd0);
      r_sig = if_a.sig ^ (rnd[7:0] & rnd[15:8]);
      r_req = rnd[30];
      r_idx = rnd[19:16];
      if_a.en = r_en; if_a.clr = r_clr; if_a.sig = r_sig;
      if_a.rd_req = r_req; if_a.rd_idx = r_idx;
      model_step(r_en, r_clr, r_sig, r_req, r_idx);
      step();
      chk("rnd rd_valid", if_a.rd_valid, m_valid);
      if (m_valid) begin
        chk("rnd rd_err",  if_a.rd_err,  m_err);
        chk("rnd rd_rise", if_a.rd_rise, m_rr);
        chk("rnd rd_fall", if_a.rd_fall, m_rf);
      end
      chk("rnd covered", if_a.covered, m_cov);
      chk("rnd sat",     if_a.sat,     m_sat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
